// File: rtl/neuron_mac_unit_if.sv
// neuron_mac_unit_if
//   Groups the signals of one neuron MAC: the start/result handshake with the
//   sequencer, and the shared read bus to the weight BRAM and activation buffer.
//   Ports (seen from the slave, i.e. the MAC unit):
//     start  in   begin one evaluation (sampled only while idle)
//     bias   in   signed Q8.8 bias, latched on the accepting edge
//     addr   out  shared read address to both buffers
//     en     out  read enable to both buffers
//     w_do   in   signed weight read on the falling edge
//     x_do   in   signed activation read on the falling edge
//     busy   out  evaluation in progress
//     done   out  one-cycle result strobe
//     out    out  signed Q8.8 neuron result, held until the next done
interface neuron_mac_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] bias;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic [DATA_W-1:0] w_do;
  logic [DATA_W-1:0] x_do;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] out;

  modport master (
    output start, bias, w_do, x_do,
    input  addr, en, busy, done, out
  );

  modport slave (
    input  start, bias, w_do, x_do,
    output addr, en, busy, done, out
  );
endinterface

// File: rtl/neuron_mac_unit.sv
// neuron_mac_unit
//   Evaluates one neuron: walks addresses 0..N_INPUTS-1 over the weight BRAM
//   and the activation buffer, accumulates the signed Q8.8 products, adds the
//   bias, rounds half-up, optionally applies ReLU and saturates to DATA_W.
//   Ports:
//     clk    rising-edge clock; the buffers read on the falling edge
//     rst_n  asynchronous active-low reset
//     bus    neuron_mac_unit_if.slave (start/bias/busy/done/out handshake and
//            addr/en/w_do/x_do buffer read bus)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; out holds the last result
//   RUN   | one product accumulated per cycle, address advancing
//   FINAL | bias add, rounding, ReLU, saturation; done strobe issued
//
// N_INPUTS must not exceed 2**ADDR_W.
module neuron_mac_unit #(
  parameter int N_INPUTS  = 28,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  neuron_mac_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL
  } state_t;

  // Two guard bits above the accumulator so bias and rounding can never wrap.
  localparam int T_W = ACC_W + 2;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(N_INPUTS - 1);
  localparam logic signed [T_W-1:0] OUT_MAX = T_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [T_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic signed [T_W-1:0] RND     = T_W'(1) <<< (FRAC_BITS - 1);

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic                       en_q, en_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [DATA_W-1:0]          out_q, out_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   bias_q, bias_d;

  logic signed [DATA_W-1:0]   w_s, x_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [T_W-1:0]      t_sum, t_shr;
  logic [DATA_W-1:0]          res;

  assign w_s      = bus.w_do;
  assign x_s      = bus.x_do;
  assign prod     = w_s * x_s;
  assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // acc is Q.16 (product of two Q8.8); bias is aligned by shifting it up.
  assign t_sum = T_W'(acc_q) + (T_W'(bias_q) <<< FRAC_BITS) + RND;
  assign t_shr = t_sum >>> FRAC_BITS;

  always_comb begin
    res = t_shr[DATA_W-1:0];
    if (RELU_EN && (t_shr < 0)) begin
      res = '0;
    end else if (t_shr > OUT_MAX) begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (t_shr < OUT_MIN) begin
      res = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    acc_d   = acc_q;
    bias_d  = bias_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bias_d  = bus.bias;
          acc_d   = '0;
          addr_d  = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Data on w_do/x_do belongs to the address presented last cycle.
        acc_d = acc_q + prod_ext;
        if (addr_q == LAST_ADDR) begin
          en_d    = 1'b0;
          state_d = FINAL;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      FINAL: begin
        out_d   = res;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      acc_q   <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
      bias_q  <= bias_d;
    end
  end

  assign bus.addr = addr_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// tb_neuron_mac_unit
//   Two instances (ReLU on / ReLU off) share one stimulus and one pair of
//   falling-edge buffer models. A cycle-index model predicts addr/en/busy/done
//   and the result is computed with plain integer arithmetic.
module tb_neuron_mac_unit;
  localparam int N = 28;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] bias = 16'h0000;
  logic [15:0] w_do = 16'h0000;
  logic [15:0] x_do = 16'h0000;

  logic signed [15:0] w_mem [N];
  logic signed [15:0] x_mem [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  neuron_mac_unit_if ifa ();
  neuron_mac_unit_if ifb ();

  assign ifa.start = start;
  assign ifa.bias  = bias;
  assign ifa.w_do  = w_do;
  assign ifa.x_do  = x_do;
  assign ifb.start = start;
  assign ifb.bias  = bias;
  assign ifb.w_do  = w_do;
  assign ifb.x_do  = x_do;

  neuron_mac_unit #(.RELU_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  neuron_mac_unit #(.RELU_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Buffers: read on the falling edge while enabled; garbage otherwise.
  always @(negedge clk) begin
    if (ifa.en) begin
      w_do = w_mem[ifa.addr];
      x_do = x_mem[ifa.addr];
    end else begin
      w_do = 16'($urandom);
      x_do = 16'($urandom);
    end
  end

  function automatic logic [15:0] neuron_ref(input logic [15:0] b, input bit relu);
    longint acc = 0;
    longint t;
    for (int i = 0; i < N; i++) acc += longint'(w_mem[i]) * longint'(x_mem[i]);
    t = acc + longint'($signed(b)) * 256 + 128;
    t = t >>> 8;
    if (relu && t < 0) t = 0;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t[15:0];
  endfunction

  // phase = rising edges since the accepting edge, -1 when idle.
  int          phase = -1;
  logic [4:0]  exp_addr = 5'd0;
  logic [15:0] exp_bias = 16'h0;
  logic [15:0] exp_out_a = 16'h0;
  logic [15:0] exp_out_b = 16'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = -1;
      exp_addr = 5'd0;
      exp_bias = 16'h0;
      exp_out_a = 16'h0;
      exp_out_b = 16'h0;
    end else if (phase < 0 || phase == N + 1) begin
      if (start) begin
        phase = 0;
        exp_bias = bias;
        exp_addr = 5'd0;
      end else begin
        phase = -1;
      end
    end else begin
      phase++;
      if (phase <= N - 1) exp_addr = 5'(phase);
      if (phase == N + 1) begin
        exp_out_a = neuron_ref(exp_bias, 1'b1);
        exp_out_b = neuron_ref(exp_bias, 1'b0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic exp_en, exp_busy, exp_done;
    exp_en   = (phase >= 0) && (phase <= N - 1);
    exp_busy = (phase >= 0) && (phase <= N);
    exp_done = (phase == N + 1);
    chk("a_addr", ifa.addr, exp_addr);
    chk("a_en",   ifa.en,   exp_en);
    chk("a_busy", ifa.busy, exp_busy);
    chk("a_done", ifa.done, exp_done);
    chk("a_out",  ifa.out,  exp_out_a);
    chk("b_addr", ifb.addr, exp_addr);
    chk("b_en",   ifb.en,   exp_en);
    chk("b_busy", ifb.busy, exp_busy);
    chk("b_done", ifb.done, exp_done);
    chk("b_out",  ifb.out,  exp_out_b);
  end

  task automatic fill(input logic [15:0] w, input logic [15:0] x);
    for (int i = 0; i < N; i++) begin
      w_mem[i] = w;
      x_mem[i] = x;
    end
  endtask

  function automatic logic [15:0] rnd16(input int mode);
    logic [15:0] r;
    r = 16'($urandom);
    if (mode == 0) return {{6{r[9]}}, r[9:0]};
    return r;
  endfunction

  // Called at posedge+1 with the unit idle; returns at posedge+1 after done.
  task automatic run_neuron(input logic [15:0] b, input bit noisy);
    int lat;
    lat = -1;
    bias  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (ifa.done) begin
        lat = c;
        break;
      end
      if (noisy) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 40 cycles, expected after 29");
    end else begin
      chk("latency", lat, 29);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, ifa.addr, 0);
    chk({tag, "_en"},   ifa.en,   0);
    chk({tag, "_busy"}, ifa.busy, 0);
    chk({tag, "_done"}, ifa.done, 0);
    chk({tag, "_out"},  ifa.out,  0);
    chk({tag, "_bout"}, ifb.out,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int nd, last;
    fill(16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill(16'h0100, 16'h0100);
    run_neuron(16'h0000, 1'b0);
    chk("ones_a", ifa.out, 16'h1C00);
    chk("ones_b", ifb.out, 16'h1C00);
    chk("ones_model", exp_out_a, 16'h1C00);

    fill(16'h0100, 16'hFF00);
    run_neuron(16'h0200, 1'b0);
    chk("neg_relu", ifa.out, 16'h0000);
    chk("neg_norelu", ifb.out, 16'hE600);
    chk("neg_model", exp_out_b, 16'hE600);

    fill(16'h7FFF, 16'h7FFF);
    run_neuron(16'h7FFF, 1'b0);
    chk("sat_pos_a", ifa.out, 16'h7FFF);
    chk("sat_pos_b", ifb.out, 16'h7FFF);

    fill(16'h7FFF, 16'h8000);
    run_neuron(16'h7FFF, 1'b0);
    chk("sat_neg_b", ifb.out, 16'h8000);
    chk("sat_neg_a", ifa.out, 16'h0000);

    fill(16'h0000, 16'h0000);
    w_mem[0] = 16'h0001;
    x_mem[0] = 16'h0080;
    run_neuron(16'h0000, 1'b0);
    chk("round_up", ifb.out, 16'h0001);
    chk("round_model", exp_out_b, 16'h0001);
    x_mem[0] = 16'h007F;
    run_neuron(16'h0000, 1'b0);
    chk("round_down", ifb.out, 16'h0000);

    for (int r = 0; r < 8; r++) begin
      int mode;
      mode = r % 2;
      for (int i = 0; i < N; i++) begin
        w_mem[i] = rnd16(mode);
        x_mem[i] = rnd16(mode);
      end
      run_neuron(rnd16(1), 1'b1);
      chk("rand_a", ifa.out, neuron_ref(bias, 1'b1));
      chk("rand_b", ifb.out, neuron_ref(bias, 1'b0));
    end

    // START held high: a new evaluation every 30 cycles.
    fill(16'h0100, 16'h0100);
    bias  = 16'h0000;
    start = 1'b1;
    nd = 0;
    last = -1;
    for (int c = 0; c < 95; c++) begin
      @(negedge clk);
      if (ifa.done) begin
        if (last >= 0) chk("restart_period", c - last, 30);
        last = c;
        nd++;
      end
    end
    start = 1'b0;
    chk("restart_count", nd, 3);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!ifa.busy && !ifa.done) break;
    end
    @(posedge clk);
    #1;

    // Reset mid-run aborts; a later run is unaffected.
    fill(16'h0100, 16'h0100);
    bias  = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("abort_no_done", ifa.done, 0);
    run_neuron(16'h0000, 1'b0);
    chk("after_abort", ifa.out, 16'h1C00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
